// File: rtl/sm_pkg.sv
// Shared types and default sizes for the sign-magnitude burst accumulator.
package sm_pkg;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Default operand width (sign + magnitude) and burst counter width
  localparam int N_DEF  = 4;
  localparam int CW_DEF = 4;

endpackage

// File: rtl/sm_add_sat.sv
// Combinational sign-magnitude adder with magnitude saturation.
// -0 operands are read as +0 and a zero result is always emitted as +0.
module sm_add_sat
  import sm_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ovf
);

  logic [N-2:0] ma;
  logic [N-2:0] mb;
  logic [N-2:0] mag;
  logic         sa;
  logic         sb;
  logic         sgn;
  logic [N-1:0] raw;

  // Clamp an N-bit magnitude sum to the largest representable magnitude
  function automatic logic [N-2:0] sat_mag(input logic [N-1:0] r);
    return r[N-1] ? {(N-1){1'b1}} : r[N-2:0];
  endfunction

  // Same-sign: add and saturate; opposite sign: larger minus smaller
  always_comb begin
    ma  = a[N-2:0];
    mb  = b[N-2:0];
    sa  = a[N-1] & (|ma);
    sb  = b[N-1] & (|mb);
    raw = {1'b0, ma} + {1'b0, mb};
    mag = '0;
    sgn = 1'b0;
    ovf = 1'b0;
    if (sa == sb) begin
      mag = sat_mag(raw);
      sgn = sa;
      ovf = raw[N-1];
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    sum = {sgn & (|mag), mag};
  end

endmodule

// File: rtl/sm_accum_ctrl.sv
// Burst accumulator: sums len sign-magnitude operands with saturation,
// presents the result under valid/ready handshake and holds it until the next start.
module sm_accum_ctrl
  import sm_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  sum,
  output logic          ovf,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  add_sum;
  logic          add_ovf;

  sm_add_sat #(.N(N)) u_add (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Next-state and datapath update selection
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = len;
          state_d = (len != '0) ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q - 1'b1;
          // cnt of 0 cannot occur here; treating it like 1 keeps the FSM from sticking
          if (cnt_q <= {{(CW-1){1'b0}}, 1'b1}) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All state registers, with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sm_accum_ctrl.sv
// Testbench for sm_accum_ctrl (N=4, CW=4): directed bursts plus randomized bursts
// checked against an integer-arithmetic reference.
module tb_sm_accum_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] sum;
  logic       ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;

  sm_accum_ctrl #(.N(4), .CW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Sign-magnitude code to signed integer (-0 becomes 0)
  function automatic int dec(input logic [3:0] x);
    int m;
    m = int'(x[2:0]);
    return x[3] ? -m : m;
  endfunction

  // Signed integer in [-7,7] to sign-magnitude code, zero always +0
  function automatic logic [3:0] enc(input int v);
    logic [2:0] m;
    if (v < 0) begin
      m = 3'(-v);
      return {1'b1, m};
    end
    m = 3'(v);
    return {1'b0, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full burst: start, feed n operands with random gaps, then hold the
  // result for 'hold' cycles (optionally poking start/in_valid) before consuming it.
  task automatic burst(input int n, input logic [63:0] ops, input int hold, input bit poke,
                       output logic [3:0] fsum, output logic fovf);
    int  v;
    bit  eo;
    int  gap;
    v  = 0;
    eo = 1'b0;
    start    = 1'b1;
    len      = 4'(n);
    in_valid = 1'($urandom_range(0, 1));
    in_data  = 4'($urandom);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("sum_cleared", sum, 0);
    chk("ovf_cleared", ovf, 0);
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("in_ready_idle_gap", in_ready, 1);
        chk("sum_idle_gap", sum, enc(v));
      end
      in_valid = 1'b1;
      in_data  = ops[4*i +: 4];
      chk("in_ready_accept", in_ready, 1);
      chk("out_valid_accum", out_valid, 0);
      tick();
      in_valid = 1'b0;
      v = v + dec(ops[4*i +: 4]);
      if (v > 7) begin
        v  = 7;
        eo = 1'b1;
      end else if (v < -7) begin
        v  = -7;
        eo = 1'b1;
      end
      chk("acc_sum", sum, enc(v));
      chk("acc_ovf", ovf, eo);
    end
    chk("out_valid_latency", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    chk("done_sum", sum, enc(v));
    chk("done_ovf", ovf, eo);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = poke;
      len       = 4'($urandom);
      in_valid  = poke;
      in_data   = 4'($urandom);
      tick();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_sum", sum, enc(v));
      chk("hold_ovf", ovf, eo);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consumed_out_valid", out_valid, 0);
    chk("consumed_busy", busy, 0);
    chk("consumed_in_ready", in_ready, 0);
    chk("consumed_sum_hold", sum, enc(v));
    chk("consumed_ovf_hold", ovf, eo);
    fsum = enc(v);
    fovf = eo;
  endtask

  initial begin
    logic [3:0] fs;
    logic       fo;
    logic [63:0] rops;

    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_sum", sum, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);

    // in_valid outside ACCUM is ignored
    in_valid = 1'b1;
    in_data  = 4'b0011;
    tick();
    in_valid = 1'b0;
    chk("idle_in_valid_ignored", sum, 0);
    chk("idle_busy", busy, 0);

    // Basic burst: 3 + 2 + (-4) = +1
    burst(3, 64'h0000_0000_0000_0C23, 0, 1'b0, fs, fo);
    chk("basic_sum", fs, 4'b0001);
    chk("basic_ovf", fo, 0);

    // Overflow: 5 + 6 saturates to 7, then -1 gives 6 with sticky ovf
    burst(3, 64'h0000_0000_0000_0965, 0, 1'b0, fs, fo);
    chk("ovf_sum", fs, 4'b0110);
    chk("ovf_flag", fo, 1);

    // Cancellation must give +0
    burst(2, 64'h0000_0000_0000_00B3, 0, 1'b0, fs, fo);
    chk("cancel_sum", fs, 4'b0000);
    chk("cancel_ovf", fo, 0);

    // -0 operands behave as +0
    burst(3, 64'h0000_0000_0000_0888, 0, 1'b0, fs, fo);
    chk("negzero_sum", fs, 4'b0000);

    // Negative saturation
    burst(2, 64'h0000_0000_0000_00FE, 0, 1'b0, fs, fo);
    chk("negsat_sum", fs, 4'b1111);
    chk("negsat_ovf", fo, 1);

    // Zero length burst goes straight to DONE
    burst(0, 64'h0, 0, 1'b0, fs, fo);
    chk("zero_len_sum", fs, 4'b0000);

    // Backpressure with start pulsed while holding
    burst(2, 64'h0000_0000_0000_0012, 3, 1'b1, fs, fo);
    chk("bp_sum", fs, 4'b0011);

    // Reset mid-burst after one of three operands
    start = 1'b1;
    len   = 4'd3;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'b0101;
    tick();
    in_valid = 1'b0;
    chk("midrst_pre_sum", sum, 4'b0101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_ovf", ovf, 0);
    tick();
    chk("midrst_no_result", out_valid, 0);

    // Reset while DONE aborts the result
    start = 1'b1;
    len   = 4'd0;
    tick();
    start = 1'b0;
    chk("donerst_pre_valid", out_valid, 1);
    reset     = 1'b1;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    chk("donerst_valid", out_valid, 0);
    chk("donerst_busy", busy, 0);

    // Randomized bursts
    for (int k = 0; k < 16; k++) begin
      rops = {$urandom, $urandom};
      burst(int'($urandom_range(0, 15)), rops, int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), fs, fo);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        tick();
        chk("rand_idle_busy", busy, 0);
        chk("rand_idle_sum_hold", sum, fs);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_accum_ctrl.md
SM_ACCUM_CTRL -- requirements
Module: sm_accum_ctrl

Interface
REQ-001 Parameter N, default 4: operand/result width, sign-magnitude format; MSB is the sign and N-1 bits are the magnitude.
REQ-002 Parameter CW, default 4: burst-length counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  burst request; sampled only in IDLE.
REQ-006 len  input  CW  operand count for the burst, sampled with start.
REQ-007 in_valid  input  1  operand valid.
REQ-008 in_data  input  N  sign-magnitude operand.
REQ-009 in_ready  output  1  operand accepted when in_valid && in_ready.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-012 sum  output  N  sign-magnitude accumulated result.
REQ-013 ovf  output  1  sticky magnitude-overflow flag for the current burst.
REQ-014 busy  output  1  high whenever state != IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM and DONE.
REQ-016 In IDLE, start=1 SHALL clear acc to +0, clear ovf and load cnt=len at that edge; next state is ACCUM if len!=0, otherwise DONE.
REQ-017 start SHALL be ignored in ACCUM and DONE; in_valid SHALL be ignored outside ACCUM.
REQ-018 in_ready SHALL equal 1 exactly when state==ACCUM.
REQ-019 Each accepted operand SHALL update acc = acc (+) in_data at that edge and decrement cnt; acceptance with cnt==1 SHALL move the FSM to DONE at the same edge.
REQ-020 out_valid SHALL be 1 exactly in DONE, so it rises the cycle after the last accepted operand, with sum=acc held stable.
REQ-021 In DONE, out_valid && out_ready SHALL return the FSM to IDLE at that edge; sum and ovf SHALL hold their values until the next start.
REQ-022 The (+) operation: if the signs are equal, add the magnitudes and keep the common sign; if the signs differ, subtract the smaller magnitude from the larger and take the sign of the larger magnitude.
REQ-023 A zero result magnitude SHALL always be encoded as +0 (sign 0); -0 SHALL never appear on sum.
REQ-024 A same-sign addition whose magnitude exceeds 2^(N-1)-1 SHALL saturate the magnitude to 2^(N-1)-1, keep the sign and set ovf.
REQ-025 ovf SHALL remain set until the next accepted start or reset.
REQ-026 An input of -0 SHALL be treated as +0.
REQ-027 Latency: 1 cycle from the last operand acceptance to out_valid; 1 cycle from start with len=0 to out_valid.

Reset
REQ-028 reset SHALL take priority over all other inputs and act at the clock edge only.
REQ-029 Reset values: state=IDLE, acc=0, cnt=0, ovf=0, so sum=0, out_valid=0, in_ready=0, busy=0.
REQ-030 Reset asserted during ACCUM or DONE SHALL abort the burst; no result is produced.

Structure
REQ-031 The state encoding type and the default N/CW constants SHALL live in the shared package sm_pkg.
REQ-032 The (+) datapath SHALL be a separate combinational sub-module, sm_add_sat, with inputs a, b and outputs sum, ovf, instantiated once.
REQ-033 All state SHALL be held in a single clocked process; next-state and datapath logic SHALL be combinational.

Verification (N=4, CW=4)
REQ-034 Burst: len=3, operands 0011, 0010, 1100 -> sum=0001, ovf=0; out_valid rises 1 cycle after the third accept.
REQ-035 Overflow: len=3, operands 0101, 0110, 1001 -> saturation to 0111 after the second operand, final sum=0110, ovf=1.
REQ-036 Cancellation: len=2, operands 0011, 1011 -> sum=0000 (not 1000), ovf=0.
REQ-037 Zero length: start with len=0 -> out_valid=1 on the next cycle, sum=0000; in_ready stays 0 throughout.
REQ-038 Backpressure: out_ready held low for 3 cycles in DONE with start pulsed -> sum and out_valid hold, start is ignored, and the FSM returns to IDLE on the out_ready edge.
REQ-039 Reset mid-burst: reset after 1 of 3 operands -> next cycle state=IDLE, sum=0000, ovf=0, busy=0, in_ready=0.
